seven_segment_scan_receiver: RTL and testbench

//  Receive end of the 7-segment display interface: samples a multiplexed segment bus plus

---
 rtl/seven_segment_scan_receiver.sv | 198 +++++++++++++++++++
 tb/tb_seven_segment_scan_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_receiver.sv
// Receive side of a multiplexed 7-segment display bus.
// Recovers the hex value shown on each digit from the segment bus and the one-hot digit select.
// A pattern must be stable for STABLE_CYCLES samples before it is captured. A stable pattern
// that is not a hex glyph produces an err_o pulse and is not written.
// Optional feature: define SEVSEG_RX_BLANK_EN to add blank_o. A stable, all-dark segment
// pattern then marks that digit as blank instead of producing an error.
module seven_segment_scan_receiver #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            seg_i,
  input  logic [DIGITS-1:0]     an_i,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [DIGITS-1:0]     dp_o,
  output logic [DIGITS-1:0]     valid_o,
  output logic                  update_o,
  output logic [2:0]            update_idx,
  output logic                  err_o
`ifdef SEVSEG_RX_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_o
`endif
);

  localparam int unsigned SampW = DIGITS + 8;
  localparam logic [7:0]  CntLim = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StCount, StCaptured} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SampW-1:0]   samp_q, samp_now;
  logic               changed, an_onehot, capture;
  logic               glyph_ok;
  logic [3:0]         glyph_hex;
  logic [2:0]         an_idx;

  logic [4*DIGITS-1:0] digits_d;
  logic [DIGITS-1:0]   dp_d, valid_d;
  logic                update_d, err_d;
  logic [2:0]          idx_d;
`ifdef SEVSEG_RX_BLANK_EN
  logic [DIGITS-1:0]   blank_d;
`endif

  // Decode the incoming segment pattern, the one-hot property and the digit index.
  always_comb begin
    samp_now  = {an_i, seg_i};
    changed   = (samp_now != samp_q);
    an_onehot = (an_i != '0) && ((an_i & (an_i - 1'b1)) == '0);
    an_idx    = 3'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (an_i[i]) an_idx = 3'(i);
    end
    glyph_ok  = 1'b1;
    glyph_hex = 4'h0;
    case (seg_i[6:0])
      7'h3F: glyph_hex = 4'h0;
      7'h06: glyph_hex = 4'h1;
      7'h5B: glyph_hex = 4'h2;
      7'h4F: glyph_hex = 4'h3;
      7'h66: glyph_hex = 4'h4;
      7'h6D: glyph_hex = 4'h5;
      7'h7D: glyph_hex = 4'h6;
      7'h07: glyph_hex = 4'h7;
      7'h7F: glyph_hex = 4'h8;
      7'h6F: glyph_hex = 4'h9;
      7'h77: glyph_hex = 4'hA;
      7'h7C: glyph_hex = 4'hB;
      7'h39: glyph_hex = 4'hC;
      7'h5E: glyph_hex = 4'hD;
      7'h79: glyph_hex = 4'hE;
      7'h71: glyph_hex = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // Stability FSM: count identical samples and fire one capture per stable window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (an_onehot) begin
          state_d = StCount;
          cnt_d   = 8'd1;
        end
      end
      StCount: begin
        if (changed) begin
          state_d = an_onehot ? StCount : StIdle;
          cnt_d   = an_onehot ? 8'd1 : 8'd0;
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (cnt_d >= CntLim) begin
            capture = 1'b1;
            state_d = StCaptured;
          end
        end
      end
      StCaptured: begin
        if (changed) begin
          state_d = an_onehot ? StCount : StIdle;
          cnt_d   = an_onehot ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Next values of the captured digit state and the one-cycle pulses.
  always_comb begin
    digits_d = digits_o;
    dp_d     = dp_o;
    valid_d  = valid_o;
    idx_d    = update_idx;
    update_d = 1'b0;
    err_d    = 1'b0;
`ifdef SEVSEG_RX_BLANK_EN
    blank_d  = blank_o;
`endif
    if (capture) begin
      if (glyph_ok) begin
        update_d = 1'b1;
        idx_d    = an_idx;
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (an_i[i]) begin
            digits_d[4*i +: 4] = glyph_hex;
            dp_d[i]            = seg_i[7];
            valid_d[i]         = 1'b1;
`ifdef SEVSEG_RX_BLANK_EN
            blank_d[i]         = 1'b0;
`endif
          end
        end
`ifdef SEVSEG_RX_BLANK_EN
      end else if (seg_i[6:0] == 7'h00) begin
        // Dark digit: record blank and dp, keep the last hex value and valid flag.
        update_d = 1'b1;
        idx_d    = an_idx;
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (an_i[i]) begin
            dp_d[i]    = seg_i[7];
            blank_d[i] = 1'b1;
          end
        end
`endif
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // FSM, counter and sample register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_now;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits_o   <= '0;
      dp_o       <= '0;
      valid_o    <= '0;
      update_o   <= 1'b0;
      update_idx <= 3'd0;
      err_o      <= 1'b0;
`ifdef SEVSEG_RX_BLANK_EN
      blank_o    <= '0;
`endif
    end else begin
      digits_o   <= digits_d;
      dp_o       <= dp_d;
      valid_o    <= valid_d;
      update_o   <= update_d;
      update_idx <= idx_d;
      err_o      <= err_d;
`ifdef SEVSEG_RX_BLANK_EN
      blank_o    <= blank_d;
`endif
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_receiver.sv
// Scoreboard bench for seven_segment_scan_receiver (DIGITS=4, STABLE_CYCLES=4).
// Each stimulus hold runs through a small window model. The model queues an expected
// capture or error event, with the cycle it must appear on. A monitor pops and compares.
module tb_seven_segment_scan_receiver;

  localparam int D = 4;
  localparam int S = 4;

  logic         clock, reset;
  logic [7:0]   seg_i;
  logic [D-1:0] an_i;
  logic [4*D-1:0] digits_o;
  logic [D-1:0] dp_o, valid_o;
  logic         update_o, err_o;
  logic [2:0]   update_idx;
`ifdef SEVSEG_RX_BLANK_EN
  logic [D-1:0] blank_o;
  localparam bit BlankEn = 1'b1;
`else
  logic [D-1:0] blank_o;
  localparam bit BlankEn = 1'b0;
  assign blank_o = '0;
`endif

  seven_segment_scan_receiver #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clock      (clock),
    .reset      (reset),
    .seg_i      (seg_i),
    .an_i       (an_i),
    .digits_o   (digits_o),
    .dp_o       (dp_o),
    .valid_o    (valid_o),
    .update_o   (update_o),
    .update_idx (update_idx),
    .err_o      (err_o)
`ifdef SEVSEG_RX_BLANK_EN
    ,
    .blank_o    (blank_o)
`endif
  );

  typedef struct {
    bit           is_err;
    logic [2:0]   idx;
    logic [4*D-1:0] digits;
    logic [D-1:0] dp;
    logic [D-1:0] valid;
    logic [D-1:0] blank;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Window model state.
  logic [D+7:0]   m_prev;
  int             m_run, m_start;
  bit             m_cap;
  logic [4*D-1:0] m_dig;
  logic [D-1:0]   m_dp, m_val, m_blank;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [6:0] glyph(input int h);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[h];
  endfunction

  function automatic bit onehot(input logic [D-1:0] a);
    return (a != 0) && ((a & (a - 1'b1)) == 0);
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_start = 0; m_cap = 0;
    m_dig = '0; m_dp = '0; m_val = '0; m_blank = '0;
  endtask

  task automatic push_event(input logic [D-1:0] an, input logic [7:0] seg);
    exp_t e;
    int   idx = 0;
    int   h   = -1;
    for (int i = 0; i < D; i++) if (an[i]) idx = i;
    for (int i = 0; i < 16; i++) if (glyph(i) == seg[6:0]) h = i;
    e.is_err = 1'b0;
    if (h >= 0) begin
      m_dig[4*idx +: 4] = 4'(h);
      m_dp[idx] = seg[7]; m_val[idx] = 1'b1; m_blank[idx] = 1'b0;
    end else if (BlankEn && seg[6:0] == 7'h00) begin
      m_dp[idx] = seg[7]; m_blank[idx] = 1'b1;
    end else begin
      e.is_err = 1'b1;
    end
    e.idx = 3'(idx); e.digits = m_dig; e.dp = m_dp; e.valid = m_val; e.blank = m_blank;
    e.cyc = m_start + S;
    sbq.push_back(e);
  endtask

  // Drive a pattern for n cycles; identical consecutive holds extend one window.
  task automatic hold(input logic [D-1:0] an, input logic [7:0] seg, input int n);
    an_i = an; seg_i = seg;
    if ({an, seg} != m_prev) begin
      m_prev = {an, seg}; m_run = 0; m_cap = 0; m_start = cyc;
    end
    m_run += n;
    if (onehot(an) && !m_cap && m_run >= S) begin
      m_cap = 1'b1;
      push_event(an, seg);
    end
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    check("rst_update", update_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_digits", digits_o, 0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; an_i = '0; seg_i = '0;
    model_reset();
    fork
      forever begin
        @(negedge clock);
        if (!reset) begin
          check("mutex", {62'd0, update_o & err_o}, 0);
          if (update_o || err_o) begin
            if (sbq.size() == 0) begin
              check("spurious", {62'd0, update_o, err_o}, 0);
            end else begin
              e = sbq.pop_front();
              check("kind_err", err_o, e.is_err);
              check("kind_upd", update_o, !e.is_err);
              check("when", cyc, e.cyc);
              check("digits", digits_o, e.digits);
              check("valid", valid_o, e.valid);
              check("dp", dp_o, e.dp);
              check("blank", blank_o, e.blank);
              if (!e.is_err) check("idx", update_idx, e.idx);
            end
          end
        end
      end
    join_none

    // Reset then idle: everything stays zero.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    hold('0, 8'h00, 50);
    check("idle_digits", digits_o, 0);
    check("idle_dp", dp_o, 0);
    check("idle_valid", valid_o, 0);
    check("idle_idx", update_idx, 0);

    // Single capture then long hold with no re-capture.
    hold(4'b0001, 8'h4F, S);
    hold(4'b0001, 8'h4F, 20);
    check("d0_value", digits_o[3:0], 4'h3);
    check("d0_valid", valid_o, 4'b0001);
    check("d0_idx", update_idx, 0);

    // All 16 glyphs on digit 2 with dp lit.
    for (int h = 0; h < 16; h++) hold(4'b0100, {1'b1, glyph(h)}, 6);
    check("d2_last", digits_o[11:8], 4'hF);
    check("d2_dp", dp_o[2], 1'b1);

    // Short glitch followed by a stable glyph: single capture of 1.
    hold(4'b0100, 8'h4F, S - 1);
    hold(4'b0100, 8'h06, S);
    check("glitch_val", digits_o[11:8], 4'h1);

    // Illegal glyph, then a non-one-hot select.
    hold(4'b0010, 8'h49, S);
    hold(4'b0011, 8'h3F, 10);
    check("err_valid", valid_o, 4'b0101);

    // Digit-select change with same segments restarts the count.
    hold(4'b1000, 8'h06, S - 1);
    hold(4'b0100, 8'h06, S);

    // Reset in the middle of a window; full window required afterwards.
    hold(4'b0001, 8'h3F, S - 1);
    pulse_reset(2);
    hold(4'b0001, 8'h3F, S - 1);
    check("post_rst_none", valid_o, 0);
    hold(4'b0001, 8'h3F, 1);

    // Dark digit with dp: blank when enabled, error otherwise; a glyph clears blank.
    hold(4'b0001, 8'h80, S);
    hold(4'b0001, 8'h7F, S);

    repeat (S + 2) @(negedge clock);
    check("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
